// File: rtl/seq_detect_ctrl_pkg.sv
// Shared types and helpers for the serial sequence-detector controller.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // A zero length is treated as one bit; anything longer than the datapath is clamped.
  function automatic int clamp_len(input int len, input int maxlen);
    if (len < 1) return 1;
    if (len > maxlen) return maxlen;
    return len;
  endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Configuration, bit-stream handshake and event bundle of the sequence-detector controller.
interface seq_detect_ctrl_if #(
  parameter int MAXLEN = 8,
  parameter int CNTW   = 8
);
  localparam int LENW = $clog2(MAXLEN + 1);

  logic              cfg_load;
  logic [MAXLEN-1:0] cfg_pattern;
  logic [LENW-1:0]   cfg_len;
  logic              cfg_overlap;
  logic [CNTW-1:0]   cfg_target;
  logic              start;
  logic              abort;
  logic              bit_valid;
  logic              bit_in;
  logic              bit_ready;
  logic              match;
  logic [CNTW-1:0]   match_count;
  logic              busy;
  logic              done;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    output start, abort, bit_valid, bit_in,
    input  bit_ready, match, match_count, busy, done
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    input  start, abort, bit_valid, bit_in,
    output bit_ready, match, match_count, busy, done
  );

endinterface

// File: rtl/seq_detect_ctrl_match.sv
// History shift register, fill counter and length-masked pattern compare.
module seq_match_core #(
  parameter int MAXLEN = 8,
  localparam int LENW  = $clog2(MAXLEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift,
  input  logic              bit_in,
  input  logic              clear,
  input  logic              overlap,
  input  logic [LENW-1:0]   len,
  input  logic [MAXLEN-1:0] pattern,
  output logic              hit
);

  logic [MAXLEN-1:0] hist_q, hist_d, mask;
  logic [LENW-1:0]   fill_q, fill_d;

  // Hit is judged on the post-shift history so the bit being accepted completes the pattern.
  always_comb begin
    hist_d = {hist_q[MAXLEN-2:0], bit_in};
    fill_d = (fill_q == LENW'(MAXLEN)) ? fill_q : fill_q + 1'b1;
    for (int i = 0; i < MAXLEN; i++) mask[i] = (i < int'(len));
    hit = shift && (fill_d >= len) && ((hist_d & mask) == (pattern & mask));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clear) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift) begin
      if (hit && !overlap) begin
        hist_q <= '0;
        fill_q <= '0;
      end else begin
        hist_q <= hist_d;
        fill_q <= fill_d;
      end
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for the 1-bit sequence detector: config registers, FSM and match counter.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int MAXLEN = 8,
  parameter int CNTW   = 8
) (
  input logic              clk,
  input logic              rst,
  seq_detect_ctrl_if.slave bus
);

  localparam int LENW = $clog2(MAXLEN + 1);

  state_t            state_q, state_d;
  logic [MAXLEN-1:0] pat_q;
  logic [LENW-1:0]   len_q;
  logic              ovl_q;
  logic [CNTW-1:0]   tgt_q;
  logic [CNTW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic              match_q, match_d, done_q, done_d;
  logic              cfg_we, clear, shift, hit;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // An abort discards the bit offered in the same cycle, so it never reaches the history.
  assign shift = (state_q == RUN) && bus.bit_valid && !bus.abort;

  seq_match_core #(.MAXLEN(MAXLEN)) u_core (
    .clk     (clk),
    .rst     (rst),
    .shift   (shift),
    .bit_in  (bus.bit_in),
    .clear   (clear),
    .overlap (ovl_q),
    .len     (len_q),
    .pattern (pat_q),
    .hit     (hit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    match_d = 1'b0;
    done_d  = 1'b0;
    clear   = 1'b0;
    cfg_we  = 1'b0;
    cnt_inc = sat_inc(cnt_q);
    case (state_q)
      IDLE: begin
        cfg_we = bus.cfg_load;
        if (bus.start) begin
          clear   = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (hit) begin
          match_d = 1'b1;
          cnt_d   = cnt_inc;
          if (tgt_q != '0 && cnt_inc == tgt_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      match_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      done_q  <= done_d;
    end
  end

  // Loading at the same edge as start means the run sees the new configuration immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q <= '0;
      len_q <= LENW'(1);
      ovl_q <= 1'b0;
      tgt_q <= '0;
    end else if (cfg_we) begin
      pat_q <= bus.cfg_pattern;
      len_q <= LENW'(clamp_len(int'(bus.cfg_len), MAXLEN));
      ovl_q <= bus.cfg_overlap;
      tgt_q <= bus.cfg_target;
    end
  end

  assign bus.bit_ready   = (state_q == RUN);
  assign bus.busy        = (state_q != IDLE);
  assign bus.match       = match_q;
  assign bus.done        = done_q;
  assign bus.match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed and randomized bench for seq_detect_ctrl with a queue-based reference model.
module tb_seq_detect_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_detect_ctrl_if #(.MAXLEN(8), .CNTW(8)) b ();
  seq_detect_ctrl_if #(.MAXLEN(8), .CNTW(2)) b2 ();

  seq_detect_ctrl #(.MAXLEN(8), .CNTW(8)) u_dut (.clk(clk), .rst(rst), .bus(b));
  seq_detect_ctrl #(.MAXLEN(8), .CNTW(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));

  // Reference model: phase 0 idle, 1 running, 2 finished; bits seen kept as a queue.
  int       m_phase;
  bit       m_q[$];
  int       m_cnt;
  bit       m_match, m_done;
  bit [7:0] m_pat;
  int       m_len;
  bit       m_ovl;
  int       m_tgt;

  task automatic model_reset();
    m_phase = 0; m_q.delete(); m_cnt = 0; m_match = 0; m_done = 0;
    m_pat = 8'h00; m_len = 1; m_ovl = 0; m_tgt = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit hit;
    int n;
    m_match = 0;
    m_done  = 0;
    case (m_phase)
      0: begin
        if (b.cfg_load) begin
          m_pat = b.cfg_pattern;
          m_len = (b.cfg_len == 0) ? 1 : ((int'(b.cfg_len) > 8) ? 8 : int'(b.cfg_len));
          m_ovl = b.cfg_overlap;
          m_tgt = int'(b.cfg_target);
        end
        if (b.start) begin
          m_cnt = 0; m_q.delete(); m_phase = 1;
        end
      end
      1: begin
        if (b.abort) m_phase = 0;
        else if (b.bit_valid) begin
          m_q.push_back(b.bit_in);
          if (m_q.size() > 8) void'(m_q.pop_front());
          n = m_q.size();
          hit = (n >= m_len);
          for (int i = 0; hit && i < m_len; i++)
            if (m_q[n - m_len + i] != m_pat[m_len - 1 - i]) hit = 0;
          if (hit) begin
            m_match = 1;
            if (m_cnt < 255) m_cnt++;
            if (!m_ovl) m_q.delete();
            if (m_tgt != 0 && m_cnt == m_tgt) begin
              m_phase = 2; m_done = 1;
            end
          end
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    chk({tag, ".ready"}, 32'(b.bit_ready), 32'(m_phase == 1));
    chk({tag, ".busy"},  32'(b.busy),      32'(m_phase != 0));
    chk({tag, ".match"}, 32'(b.match),     32'(m_match));
    chk({tag, ".done"},  32'(b.done),      32'(m_done));
    chk({tag, ".count"}, 32'(b.match_count), 32'(m_cnt));
  endtask

  task automatic idle_inputs();
    b.cfg_load = 0; b.cfg_pattern = '0; b.cfg_len = '0; b.cfg_overlap = 0; b.cfg_target = '0;
    b.start = 0; b.abort = 0; b.bit_valid = 0; b.bit_in = 0;
  endtask

  task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                          input logic [7:0] tgt);
    b.cfg_load = 1; b.cfg_pattern = pat; b.cfg_len = len; b.cfg_overlap = ovl; b.cfg_target = tgt;
    step("load");
    b.cfg_load = 0;
  endtask

  task automatic start_run();
    b.start = 1; step("start"); b.start = 0;
  endtask

  task automatic abort_run();
    b.abort = 1; step("abort"); b.abort = 0;
  endtask

  task automatic send_bit(input logic v);
    b.bit_valid = 1; b.bit_in = v; step("bit"); b.bit_valid = 0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    b2.cfg_load = 0; b2.cfg_pattern = '0; b2.cfg_len = '0; b2.cfg_overlap = 0; b2.cfg_target = '0;
    b2.start = 0; b2.abort = 0; b2.bit_valid = 0; b2.bit_in = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", 32'(b.bit_ready), 0);
    chk("rst.busy",  32'(b.busy), 0);
    chk("rst.match", 32'(b.match), 0);
    chk("rst.done",  32'(b.done), 0);
    chk("rst.count", 32'(b.match_count), 0);
    rst = 0;

    // Bits offered in IDLE are ignored
    send_bit(1); send_bit(1); send_bit(1);
    chk("idle.count", 32'(b.match_count), 0);
    chk("idle.ready", 32'(b.bit_ready), 0);

    // Non-overlap 100
    load_cfg(8'b100, 4'd3, 1'b0, 8'd0);
    start_run();
    send_bit(1); send_bit(0);
    chk("n100.nomatch", 32'(b.match), 0);
    send_bit(0);
    chk("n100.m1", 32'(b.match), 1);
    send_bit(1); send_bit(0); send_bit(0);
    chk("n100.m2", 32'(b.match), 1);
    chk("n100.count", 32'(b.match_count), 2);
    abort_run();

    // Overlap versus non-overlap on 101
    load_cfg(8'b101, 4'd3, 1'b1, 8'd0);
    start_run();
    send_bit(1); send_bit(0); send_bit(1); send_bit(0); send_bit(1);
    chk("ovl.count", 32'(b.match_count), 2);
    abort_run();
    load_cfg(8'b101, 4'd3, 1'b0, 8'd0);
    start_run();
    send_bit(1); send_bit(0); send_bit(1); send_bit(0); send_bit(1);
    chk("novl.count", 32'(b.match_count), 1);
    abort_run();

    // Target stop with overlap on 11
    load_cfg(8'b11, 4'd2, 1'b1, 8'd2);
    start_run();
    send_bit(1); send_bit(1);
    chk("tgt.m1", 32'(b.match), 1);
    send_bit(1);
    chk("tgt.m2", 32'(b.match), 1);
    chk("tgt.done", 32'(b.done), 1);
    chk("tgt.ready", 32'(b.bit_ready), 0);
    send_bit(1);
    chk("tgt.idle", 32'(b.busy), 0);
    chk("tgt.nomatch", 32'(b.match), 0);
    chk("tgt.count", 32'(b.match_count), 2);

    // Abort while a completing bit is offered
    load_cfg(8'b11, 4'd2, 1'b0, 8'd0);
    start_run();
    send_bit(1); send_bit(1); send_bit(1);
    b.abort = 1; b.bit_valid = 1; b.bit_in = 1;
    step("abortbit");
    b.abort = 0; b.bit_valid = 0;
    chk("abort.match", 32'(b.match), 0);
    chk("abort.done", 32'(b.done), 0);
    chk("abort.busy", 32'(b.busy), 0);
    chk("abort.count", 32'(b.match_count), 1);

    // Zero length acts as one; config load during RUN is ignored
    load_cfg(8'h01, 4'd0, 1'b0, 8'd0);
    start_run();
    send_bit(1); send_bit(0); send_bit(1);
    chk("len0.count", 32'(b.match_count), 2);
    b.cfg_load = 1; b.cfg_pattern = 8'h00; b.cfg_len = 4'd1;
    step("runload");
    b.cfg_load = 0;
    send_bit(1);
    chk("runload.match", 32'(b.match), 1);
    send_bit(0);
    chk("runload.count", 32'(b.match_count), 3);
    abort_run();

    // 2-bit counter saturates at 3
    b2.cfg_load = 1; b2.cfg_pattern = 8'h01; b2.cfg_len = 4'd1;
    @(posedge clk); #1;
    b2.cfg_load = 0; b2.start = 1;
    @(posedge clk); #1;
    b2.start = 0; b2.bit_valid = 1; b2.bit_in = 1;
    repeat (5) @(posedge clk);
    #1;
    b2.bit_valid = 0;
    chk("sat.count", 32'(b2.match_count), 3);
    chk("sat.busy", 32'(b2.busy), 1);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      b.cfg_load    = ($urandom_range(0, 11) == 0);
      b.cfg_pattern = 8'($urandom);
      b.cfg_len     = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      b.cfg_overlap = 1'($urandom);
      b.cfg_target  = 8'($urandom_range(0, 4));
      b.start       = ($urandom_range(0, 7) == 0);
      b.abort       = ($urandom_range(0, 39) == 0);
      b.bit_valid   = ($urandom_range(0, 3) != 0);
      b.bit_in      = 1'($urandom);
      step("rnd");
    end
    idle_inputs();

    // Asynchronous reset mid-run
    load_cfg(8'h01, 4'd1, 1'b0, 8'd0);
    start_run();
    send_bit(1);
    rst = 1;
    #2;
    chk("arst.ready", 32'(b.bit_ready), 0);
    chk("arst.busy",  32'(b.busy), 0);
    chk("arst.match", 32'(b.match), 0);
    chk("arst.count", 32'(b.match_count), 0);
    model_reset();
    #2;
    rst = 0;
    step("postrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
